// File: rtl/spi_transfer_controller.sv
// Sequences one full-duplex SPI byte transfer: loads the sender, drives SCLK/CS_N,
// strobes the receiver and hands the received byte back through a START/BUSY/DONE handshake.
module spi_transfer_controller #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       START,
  input  logic       ABORT,
  input  logic [7:0] TX_DATA,
  input  logic [7:0] RX_BUS,
  output logic [7:0] SR_DATA,
  output logic       WRITE,
  output logic       TE,
  output logic       RE,
  output logic       READ,
  output logic       SCLK,
  output logic       CS_N,
  output logic       BUSY,
  output logic       DONE,
  output logic       ABORTED,
  output logic [7:0] RX_DATA
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_READ,
    ST_DONE
  } state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = (CS_HOLD == 0) ? 8'd0 : 8'(CS_HOLD - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] div_cnt;
  logic [7:0] cs_cnt;
  logic [2:0] bit_cnt;
  logic       sclk_phase;
  logic       div_end;
  logic       period_end;
  logic       accept;

  assign div_end    = (div_cnt == DIV_LAST);
  assign period_end = div_end && sclk_phase;
  assign accept     = START && ((state == ST_IDLE) || ((state == ST_DONE) && !ABORT));

  always_comb begin
    state_next = state;
    if ((state != ST_IDLE) && ABORT) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (START) state_next = ST_LOAD;
        ST_LOAD:  state_next = ST_SETUP;
        ST_SETUP: if (cs_cnt == SETUP_LAST) state_next = ST_SHIFT;
        ST_SHIFT: begin
          if (period_end && (bit_cnt == 3'd7))
            state_next = (CS_HOLD == 0) ? ST_READ : ST_HOLD;
        end
        ST_HOLD:  if (cs_cnt == HOLD_LAST) state_next = ST_READ;
        ST_READ:  state_next = ST_DONE;
        ST_DONE:  state_next = START ? ST_LOAD : ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Every counter restarts from zero on any state change, so each state sees a fresh count.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state      <= ST_IDLE;
      div_cnt    <= 8'd0;
      cs_cnt     <= 8'd0;
      bit_cnt    <= 3'd0;
      sclk_phase <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        div_cnt    <= 8'd0;
        cs_cnt     <= 8'd0;
        bit_cnt    <= 3'd0;
        sclk_phase <= 1'b0;
      end else begin
        if ((state == ST_SETUP) || (state == ST_HOLD))
          cs_cnt <= cs_cnt + 8'd1;
        if (state == ST_SHIFT) begin
          if (div_end) begin
            div_cnt    <= 8'd0;
            sclk_phase <= ~sclk_phase;
            if (sclk_phase)
              bit_cnt <= bit_cnt + 3'd1;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      SR_DATA <= 8'h00;
      RX_DATA <= 8'h00;
      ABORTED <= 1'b0;
    end else begin
      if (accept)
        SR_DATA <= TX_DATA;
      if ((state == ST_READ) && !ABORT)
        RX_DATA <= RX_BUS;
      ABORTED <= ABORT && (state != ST_IDLE);
    end
  end

  // Strobes decode straight from the state register so reset forces them inactive at once.
  assign WRITE = (state == ST_LOAD);
  assign TE    = (state == ST_SHIFT);
  assign RE    = (state == ST_SHIFT);
  assign READ  = (state == ST_READ);
  assign SCLK  = (state == ST_SHIFT) && sclk_phase;
  assign CS_N  = !((state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD));
  assign BUSY  = (state != ST_IDLE);
  assign DONE  = (state == ST_DONE);

endmodule

// File: tb/tb_spi_transfer_controller.sv
// Scoreboard bench for spi_transfer_controller: default instance plus a CLK_DIV=1, CS_HOLD=0 instance.
module tb_spi_transfer_controller;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_bus = 8'h00;
  logic [7:0] sr_data, rx_data;
  logic       write, te, re, read, sclk, cs_n, busy, done, aborted;

  logic       start_b = 1'b0;
  logic [7:0] rx_bus_b = 8'h5A;
  logic [7:0] sr_data_b, rx_data_b;
  logic       write_b, te_b, re_b, read_b, sclk_b, cs_n_b, busy_b, done_b, aborted_b;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         rise_cnt = 0;
  int         high_run = 0;
  logic       sclk_prev = 1'b0;
  exp_t       wr_q[$];
  exp_t       dn_q[$];
  logic [7:0] rx_q[$];

  spi_transfer_controller dut (
    .CLK(clk), .CLR(clr), .START(start), .ABORT(abort), .TX_DATA(tx_data), .RX_BUS(rx_bus),
    .SR_DATA(sr_data), .WRITE(write), .TE(te), .RE(re), .READ(read), .SCLK(sclk),
    .CS_N(cs_n), .BUSY(busy), .DONE(done), .ABORTED(aborted), .RX_DATA(rx_data)
  );

  spi_transfer_controller #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(0)) dut_b (
    .CLK(clk), .CLR(clr), .START(start_b), .ABORT(1'b0), .TX_DATA(8'h77), .RX_BUS(rx_bus_b),
    .SR_DATA(sr_data_b), .WRITE(write_b), .TE(te_b), .RE(re_b), .READ(read_b), .SCLK(sclk_b),
    .CS_N(cs_n_b), .BUSY(busy_b), .DONE(done_b), .ABORTED(aborted_b), .RX_DATA(rx_data_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drives one START pulse and records what the DUT owes for this transfer.
  task automatic applyStimulus(input logic [7:0] tx, input logic [7:0] rx);
    int e0;
    @(negedge clk);
    e0 = cyc + 1;
    start = 1'b1;
    tx_data = tx;
    wr_q.push_back('{data: tx, cyc: e0});
    dn_q.push_back('{data: rx, cyc: e0 + 38});
    rx_q.push_back(rx);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (dn_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (dn_q.size() != 0) begin
      checkOutput("drain_timeout", dn_q.size(), 0);
      dn_q.delete();
      wr_q.delete();
      rx_q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: feeds RX_BUS during READ and pops expectations as WRITE/DONE appear.
  always @(negedge clk) begin
    exp_t e;
    if (!clr) begin
      rise_cnt = 0;
      high_run = 0;
      sclk_prev = 1'b0;
      rx_bus = 8'h00;
    end else begin
      if (read) rx_bus = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hEE;
      else rx_bus = 8'($urandom);
      if (sclk) checkOutput("sclk_ctx", {29'd0, te, re, cs_n}, 32'b110);
      if (sclk && !sclk_prev) rise_cnt++;
      if (sclk) high_run++;
      else if (sclk_prev) begin
        checkOutput("sclk_high", high_run, 2);
        high_run = 0;
      end
      sclk_prev = sclk;
      if (write) begin
        if (wr_q.size() == 0) checkOutput("extra_write", 1, 0);
        else begin
          e = wr_q.pop_front();
          checkOutput("write_cyc", cyc, e.cyc);
          checkOutput("sr_data", {24'd0, sr_data}, {24'd0, e.data});
        end
        rise_cnt = 0;
      end
      if (done) begin
        if (dn_q.size() == 0) checkOutput("extra_done", 1, 0);
        else begin
          e = dn_q.pop_front();
          checkOutput("done_cyc", cyc, e.cyc);
          checkOutput("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          checkOutput("sclk_rises", rise_cnt, 8);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0, e1, n, rises;
    logic prev;

    repeat (3) @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("rst_idle", {23'd0, cs_n, busy, write, te, re, read, sclk, done, aborted}, 32'h100);
      checkOutput("rst_rx", {24'd0, rx_data}, 0);
    end

    $display("[TB] single transfer");
    applyStimulus(8'hA5, 8'h3C);
    drain(60);

    // START stays high through DONE, so the second transfer is accepted on the DONE edge.
    $display("[TB] back-to-back");
    @(negedge clk);
    e0 = cyc + 1;
    start = 1'b1;
    tx_data = 8'h96;
    wr_q.push_back('{data: 8'h96, cyc: e0});
    dn_q.push_back('{data: 8'h71, cyc: e0 + 38});
    rx_q.push_back(8'h71);
    @(negedge clk);
    tx_data = 8'h4B;
    repeat (38) @(negedge clk);
    checkOutput("b2b_done_now", {31'd0, done}, 1);
    e1 = e0 + 39;
    wr_q.push_back('{data: 8'h4B, cyc: e1});
    dn_q.push_back('{data: 8'h2D, cyc: e1 + 38});
    rx_q.push_back(8'h2D);
    @(negedge clk);
    start = 1'b0;
    drain(60);

    $display("[TB] start ignored during shift");
    applyStimulus(8'hC3, 8'h81);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(60);

    $display("[TB] abort at fifth sclk period");
    applyStimulus(8'h11, 8'h22);
    rises = 0;
    prev = 1'b0;
    n = 0;
    while (n < 60) begin
      if (sclk && !prev) rises++;
      prev = sclk;
      if (rises == 4 && !sclk && te) break;
      @(negedge clk);
      n++;
    end
    checkOutput("abort_reach", {31'd0, n < 60}, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    void'(dn_q.pop_back());
    void'(rx_q.pop_back());
    checkOutput("abort_outs", {25'd0, cs_n, te, re, sclk, aborted, busy, done}, 32'b1000100);
    checkOutput("abort_rx_hold", {24'd0, rx_data}, 32'h81);
    @(negedge clk);
    checkOutput("aborted_pulse", {31'd0, aborted}, 0);
    repeat (45) @(negedge clk);

    $display("[TB] async reset mid-shift");
    applyStimulus(8'h5E, 8'h6F);
    n = 0;
    while (!sclk && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("sclk_seen", {31'd0, sclk}, 1);
    #2;
    clr = 1'b0;
    #1;
    checkOutput("async_rst", {29'd0, cs_n, sclk, busy}, 32'b100);
    void'(dn_q.pop_back());
    void'(rx_q.pop_back());
    repeat (3) @(negedge clk);
    clr = 1'b1;
    checkOutput("rst_rx_clear", {24'd0, rx_data}, 0);
    repeat (45) @(negedge clk);

    $display("[TB] CLK_DIV=1 CS_HOLD=0 instance");
    @(negedge clk);
    e0 = cyc + 1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    rises = 0;
    prev = 1'b0;
    n = 0;
    while (!done_b && n < 60) begin
      if (sclk_b && !prev) rises++;
      prev = sclk_b;
      @(negedge clk);
      n++;
    end
    checkOutput("b_done_cyc", cyc, e0 + 20);
    checkOutput("b_rises", rises, 8);
    checkOutput("b_rx_data", {24'd0, rx_data_b}, 32'h5A);
    checkOutput("b_sr_data", {24'd0, sr_data_b}, 32'h77);

    @(negedge clk);
    checkOutput("pending_done", dn_q.size(), 0);
    checkOutput("pending_write", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
